// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - stream FIFO controller driving a dual-port RAM, with a 2-entry output skid stage
// Optional feature macro: FIFO_LEVEL_EN (adds the registered `level` occupancy port)
module ram_fifo_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_read_en,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_read_data
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ADDR_W+1:0] level
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(1 << ADDR_W);

    logic [ADDR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]              ram_cnt_q, ram_cnt_d;
    logic                         rd_inflight_q, rd_inflight_d;
    logic [1:0][DATA_W-1:0]       skid_q, skid_d;
    logic                         head_q, head_d;
    logic                         tail_q, tail_d;
    logic [1:0]                   skid_cnt_q, skid_cnt_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_W-1:0]            out_data_q, out_data_d;

    logic                         push;
    logic                         pop;
    logic                         issue;
    logic [2:0]                   skid_claim;

    // Handshakes and read scheduling; the skid stage plus the read in flight never exceed two words
    always_comb begin
        in_ready   = (ram_cnt_q != FULL_CNT);
        push       = in_valid && in_ready && !rst;
        pop        = out_valid_q && out_ready;
        skid_claim = {1'b0, skid_cnt_q} + {2'b00, rd_inflight_q};
        issue      = !rst && (ram_cnt_q != '0) && (skid_claim < (3'd2 + {2'b00, pop}));
    end

    assign ram_write_en   = push;
    assign ram_write_addr = wr_ptr_q;
    assign ram_write_data = in_data;
    assign ram_read_en    = issue;
    assign ram_read_addr  = rd_ptr_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;

    // Next-state for pointers, RAM occupancy and the skid ring
    always_comb begin
        wr_ptr_d      = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d      = rd_ptr_q + ADDR_W'(issue);
        ram_cnt_d     = ram_cnt_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
        rd_inflight_d = issue;
        skid_d        = skid_q;
        tail_d        = tail_q;
        head_d        = head_q ^ pop;
        if (rd_inflight_q) begin
            skid_d[tail_q] = ram_read_data;
            tail_d         = ~tail_q;
        end
        skid_cnt_d  = skid_cnt_q + {1'b0, rd_inflight_q} - {1'b0, pop};
        out_valid_d = (skid_cnt_d != 2'd0);
        out_data_d  = skid_d[head_d];
    end

    // State update; reset drops every queued word and ignores the read returning next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            skid_cnt_q    <= 2'd0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            skid_cnt_q    <= skid_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    // Skid storage carries no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

`ifdef FIFO_LEVEL_EN
    logic [ADDR_W+1:0] level_q;

    // Total words held after this edge: RAM, read in flight, skid stage
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= (ADDR_W+2)'(ram_cnt_d) + (ADDR_W+2)'(rd_inflight_d) + (ADDR_W+2)'(skid_cnt_d);
        end
    end

    assign level = level_q;
`endif

endmodule
